// File: rtl/gametank_clk_pkg.sv
// gametank_clk_pkg
// Shared definitions for the GameTank clock-enable block:
//   - sequencer FSM state encoding
//   - default fractional NUM/DEN pairs for the CPU and audio enables
//   - nominal clk frequency of the PLL divided output
//   - helper that sizes a phase accumulator for a given modulus
package gametank_clk_pkg;

    // Nominal frequency of the PLL divided output that clocks the block.
    localparam int CLK_FREQ_HZ = 21600000;

    // CPU enable: 3.579545 MHz out of 21.6 MHz.
    localparam int CPU_NUM_DEFAULT = 3579545;
    localparam int CPU_DEN_DEFAULT = CLK_FREQ_HZ;

    // Audio enable: 14 kHz out of 21.6 MHz.
    localparam int AUX_NUM_DEFAULT = 14000;
    localparam int AUX_DEN_DEFAULT = CLK_FREQ_HZ;

    // Reset sequencer states.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STRETCH   = 2'd1,
        ST_RUN       = 2'd2
    } seq_state_t;

    // An accumulator holds values below DEN, and acc + NUM stays below
    // 2*DEN, so one bit above $clog2(DEN) is enough for the sum.
    function automatic int acc_width(input int den);
        return $clog2(den) + 1;
    endfunction

endpackage

// File: rtl/gametank_clock_enables_if.sv
// gametank_clock_enables_if
// Bundles the lock input, halt handshake and generated enables/reset of
// the GameTank clock-enable block.
//   pll_lock  : PLL lock, asynchronous to clk (master -> slave)
//   halt_req  : level request to freeze ce_cpu (master -> slave)
//   halt_ack  : ce_cpu is frozen (slave -> master)
//   sys_reset : synchronous active-high reset for downstream logic
//   ce_cpu    : one-cycle CPU enable pulse
//   ce_aux    : one-cycle auxiliary (audio) enable pulse
// The slave modport is the clock-enable block; the master is its user.
interface gametank_clock_enables_if;
    import gametank_clk_pkg::*;

    logic pll_lock;
    logic halt_req;
    logic halt_ack;
    logic sys_reset;
    logic ce_cpu;
    logic ce_aux;

    modport master (
        output pll_lock,
        output halt_req,
        input  halt_ack,
        input  sys_reset,
        input  ce_cpu,
        input  ce_aux
    );

    modport slave (
        input  pll_lock,
        input  halt_req,
        output halt_ack,
        output sys_reset,
        output ce_cpu,
        output ce_aux
    );

endinterface

// File: rtl/gametank_clock_enables_accum.sv
// frac_ce_accum
// Fractional phase accumulator producing a registered one-cycle enable
// at an average rate of clk*NUM/DEN. Pulse spacing is always floor or
// ceil of DEN/NUM cycles.
//   clk    : block clock
//   clr    : synchronous clear of phase and enable (held while not running)
//   ce_out : one-cycle enable, issued the cycle after an overflow
module frac_ce_accum
    import gametank_clk_pkg::*;
#(
    parameter int NUM = 3,
    parameter int DEN = 10
) (
    input  logic clk,
    input  logic clr,
    output logic ce_out
);

    localparam int ACC_W = acc_width(DEN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    assign sum = acc + ACC_W'(NUM);

    // Each running cycle advances the phase by NUM. Crossing DEN wraps
    // the phase and schedules an enable pulse for the following cycle.
    // Clearing puts both the phase and any pending pulse back to zero so
    // a fresh run always starts from the same grid.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc    <= '0;
            ce_out <= 1'b0;
        end else if (sum >= ACC_W'(DEN)) begin
            acc    <= sum - ACC_W'(DEN);
            ce_out <= 1'b1;
        end else begin
            acc    <= sum;
            ce_out <= 1'b0;
        end
    end

endmodule

// File: rtl/gametank_clock_enables.sv
// gametank_clock_enables
// Sits behind the GameTank system PLL in its 21.6 MHz domain. Turns PLL
// lock into a stretched synchronous system reset, generates fractional
// CPU and auxiliary clock-enable pulses, and lets DMA/blitter logic halt
// the CPU enable on a CPU-cycle boundary.
//   clk   : 21.6 MHz PLL divided output
//   reset : synchronous active-high reset
//   bus   : pll_lock/halt_req in, halt_ack/sys_reset/ce_cpu/ce_aux out
module gametank_clock_enables
    import gametank_clk_pkg::*;
#(
    parameter int CPU_NUM      = CPU_NUM_DEFAULT,
    parameter int CPU_DEN      = CPU_DEN_DEFAULT,
    parameter int AUX_NUM      = AUX_NUM_DEFAULT,
    parameter int AUX_DEN      = AUX_DEN_DEFAULT,
    parameter int RESET_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    gametank_clock_enables_if.slave bus
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

    logic             lock_meta;
    logic             lock_s;
    seq_state_t       state;
    logic [CNT_W-1:0] stretch_cnt;
    logic             sys_reset_q;
    logic             halt_ack_q;
    logic             run_next;
    logic             accum_clr;
    logic             cpu_ce_raw;
    logic             aux_ce_raw;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Reset sequencer. After lock, sys_reset is held for RESET_CYCLES
    // cycles in STRETCH before releasing in RUN. Losing lock anywhere
    // drops back to WAIT_LOCK with the stretch counter cleared, so a
    // glitchy lock always restarts the full stretch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT_LOCK;
            stretch_cnt <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    sys_reset_q <= 1'b1;
                    if (lock_s) begin
                        state       <= ST_STRETCH;
                        stretch_cnt <= '0;
                    end
                end
                ST_STRETCH: begin
                    if (!lock_s) begin
                        state       <= ST_WAIT_LOCK;
                        stretch_cnt <= '0;
                        sys_reset_q <= 1'b1;
                    end else if (stretch_cnt == CNT_LAST) begin
                        state       <= ST_RUN;
                        stretch_cnt <= '0;
                        sys_reset_q <= 1'b0;
                    end else begin
                        stretch_cnt <= stretch_cnt + CNT_W'(1);
                        sys_reset_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state       <= ST_WAIT_LOCK;
                        sys_reset_q <= 1'b1;
                    end else begin
                        sys_reset_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_WAIT_LOCK;
                    stretch_cnt <= '0;
                    sys_reset_q <= 1'b1;
                end
            endcase
        end
    end

    // The accumulators and handshake look one cycle ahead at whether the
    // sequencer stays in RUN, so on lock loss the enables and halt_ack
    // clear on the very edge where sys_reset rises.
    assign run_next  = (state == ST_RUN) && lock_s && !reset;
    assign accum_clr = !run_next;

    frac_ce_accum #(
        .NUM (CPU_NUM),
        .DEN (CPU_DEN)
    ) u_cpu_accum (
        .clk    (clk),
        .clr    (accum_clr),
        .ce_out (cpu_ce_raw)
    );

    frac_ce_accum #(
        .NUM (AUX_NUM),
        .DEN (AUX_DEN)
    ) u_aux_accum (
        .clk    (clk),
        .clr    (accum_clr),
        .ce_out (aux_ce_raw)
    );

    // Halt handshake. A pending request lets the next CPU pulse through
    // and acknowledges on the following cycle, so the CPU always stops
    // on a cycle boundary. Dropping the request releases the ack on the
    // next cycle; the CPU accumulator never stops, so pulses resume on
    // the original phase grid without replaying missed ones.
    always_ff @(posedge clk) begin
        if (!run_next) begin
            halt_ack_q <= 1'b0;
        end else if (!bus.halt_req) begin
            halt_ack_q <= 1'b0;
        end else if (cpu_ce_raw) begin
            halt_ack_q <= 1'b1;
        end
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.halt_ack  = halt_ack_q;
    assign bus.ce_cpu    = cpu_ce_raw & ~halt_ack_q;
    assign bus.ce_aux    = aux_ce_raw;

endmodule

// File: tb/tb_gametank_clock_enables.sv
// tb_gametank_clock_enables
// Drives two instances of the clock-enable block from a shared lock:
//   dut_a : CPU 3/10, AUX 7/50, RESET_CYCLES 4 (halt handshake exercised)
//   dut_b : default CPU and AUX rates, RESET_CYCLES 4 (halt never requested)
// Expected enables come from the long-run rate rule: after the n-th RUN
// cycle a pulse appears whenever floor(n*NUM/DEN) steps up.
module tb_gametank_clock_enables;

    localparam longint A_CPU_NUM = 3;
    localparam longint A_CPU_DEN = 10;
    localparam longint A_AUX_NUM = 7;
    localparam longint A_AUX_DEN = 50;
    localparam longint B_CPU_NUM = 3579545;
    localparam longint B_CPU_DEN = 21600000;
    localparam longint B_AUX_NUM = 14000;
    localparam longint B_AUX_DEN = 21600000;
    localparam int     LOCK_EDGES = 7;

    logic clk;
    logic reset;

    gametank_clock_enables_if bus_a ();
    gametank_clock_enables_if bus_b ();

    gametank_clock_enables #(
        .CPU_NUM      (3),
        .CPU_DEN      (10),
        .AUX_NUM      (7),
        .AUX_DEN      (50),
        .RESET_CYCLES (4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    gametank_clock_enables #(
        .RESET_CYCLES (4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int   vectors;
    int   miscompares;
    int   n;
    logic model_ack;
    logic model_issued;
    int   cnt_a;
    int   cnt_b;
    int   last_a;
    int   last_b;
    bit   spacing_a_on;
    int   first_a[$];

    // Free-running 100 MHz-style bench clock; absolute period is irrelevant.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never returns.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "[TB] watchdog");
    end

    // Pulse expected after the k-th RUN cycle for a NUM/DEN rate.
    function automatic bit grid_pulse(input int k, input longint num, input longint den);
        if (k < 1) return 1'b0;
        return ((longint'(k) * num) / den) != ((longint'(k - 1) * num) / den);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lock(input logic v);
        bus_a.pll_lock = v;
        bus_b.pll_lock = v;
    endtask

    task automatic start_run();
        n            = 0;
        model_ack    = 1'b0;
        model_issued = 1'b0;
        cnt_a        = 0;
        cnt_b        = 0;
        last_a       = 0;
        last_b       = 0;
        first_a.delete();
    endtask

    // One RUN cycle: apply halt_req, clock, and compare every output of
    // both instances against the rate rule and the halt handshake rule.
    task automatic step(input logic h);
        logic new_ack;
        logic exp_cpu_a;
        logic exp_aux_a;
        logic exp_cpu_b;
        logic exp_aux_b;
        int   sp;
        bus_a.halt_req = h;
        tick();
        n++;
        new_ack   = h && (model_ack || model_issued);
        exp_cpu_a = grid_pulse(n, A_CPU_NUM, A_CPU_DEN) && !new_ack;
        exp_aux_a = grid_pulse(n, A_AUX_NUM, A_AUX_DEN);
        exp_cpu_b = grid_pulse(n, B_CPU_NUM, B_CPU_DEN);
        exp_aux_b = grid_pulse(n, B_AUX_NUM, B_AUX_DEN);

        vectors++;
        if (bus_a.sys_reset !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sys_reset_a n=%0d: got %b expected 0", n, bus_a.sys_reset);
        end
        vectors++;
        if (bus_a.halt_ack !== new_ack) begin
            miscompares++;
            $display("[TB] FAIL halt_ack_a n=%0d: got %b expected %b", n, bus_a.halt_ack, new_ack);
        end
        vectors++;
        if (bus_a.ce_cpu !== exp_cpu_a) begin
            miscompares++;
            $display("[TB] FAIL ce_cpu_a n=%0d: got %b expected %b", n, bus_a.ce_cpu, exp_cpu_a);
        end
        vectors++;
        if (bus_a.ce_aux !== exp_aux_a) begin
            miscompares++;
            $display("[TB] FAIL ce_aux_a n=%0d: got %b expected %b", n, bus_a.ce_aux, exp_aux_a);
        end
        vectors++;
        if (bus_b.sys_reset !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sys_reset_b n=%0d: got %b expected 0", n, bus_b.sys_reset);
        end
        vectors++;
        if (bus_b.ce_cpu !== exp_cpu_b) begin
            miscompares++;
            $display("[TB] FAIL ce_cpu_b n=%0d: got %b expected %b", n, bus_b.ce_cpu, exp_cpu_b);
        end
        vectors++;
        if (bus_b.ce_aux !== exp_aux_b) begin
            miscompares++;
            $display("[TB] FAIL ce_aux_b n=%0d: got %b expected %b", n, bus_b.ce_aux, exp_aux_b);
        end

        if (bus_a.ce_cpu === 1'b1) begin
            if (spacing_a_on && last_a > 0) begin
                sp = n - last_a;
                vectors++;
                if (!(sp == 3 || sp == 4)) begin
                    miscompares++;
                    $display("[TB] FAIL spacing_a n=%0d: got %0d expected 3 or 4", n, sp);
                end
            end
            if (first_a.size() < 3) first_a.push_back(n);
            last_a = n;
            cnt_a++;
        end
        if (bus_b.ce_cpu === 1'b1) begin
            if (last_b > 0) begin
                sp = n - last_b;
                vectors++;
                if (!(sp == 6 || sp == 7)) begin
                    miscompares++;
                    $display("[TB] FAIL spacing_b n=%0d: got %0d expected 6 or 7", n, sp);
                end
            end
            last_b = n;
            cnt_b++;
        end

        model_ack    = new_ack;
        model_issued = exp_cpu_a;
    endtask

    // Raise lock right after an edge and check that sys_reset falls on
    // exactly the LOCK_EDGES-th edge, with all enables quiet until then.
    task automatic do_lock_sequence(input string tag);
        logic exp_rst;
        set_lock(1'b1);
        for (int e = 1; e <= LOCK_EDGES; e++) begin
            tick();
            exp_rst = (e < LOCK_EDGES);
            vectors++;
            if (bus_a.sys_reset !== exp_rst || bus_b.sys_reset !== exp_rst) begin
                miscompares++;
                $display("[TB] FAIL %s_sys_reset edge=%0d: got a=%b b=%b expected %b",
                         tag, e, bus_a.sys_reset, bus_b.sys_reset, exp_rst);
            end
            if (exp_rst) begin
                vectors++;
                if ({bus_a.ce_cpu, bus_a.ce_aux, bus_a.halt_ack, bus_b.ce_cpu, bus_b.ce_aux} !== 5'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s_enables edge=%0d: got %b%b%b%b%b expected 00000", tag, e,
                             bus_a.ce_cpu, bus_a.ce_aux, bus_a.halt_ack, bus_b.ce_cpu, bus_b.ce_aux);
                end
            end
        end
        start_run();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_lock(1'b0);
        bus_a.halt_req = 1'b0;
        bus_b.halt_req = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({bus_a.sys_reset, bus_a.ce_cpu, bus_a.ce_aux, bus_a.halt_ack} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_a: got %b%b%b%b expected 1000",
                     bus_a.sys_reset, bus_a.ce_cpu, bus_a.ce_aux, bus_a.halt_ack);
        end
        vectors++;
        if ({bus_b.sys_reset, bus_b.ce_cpu, bus_b.ce_aux, bus_b.halt_ack} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_b: got %b%b%b%b expected 1000",
                     bus_b.sys_reset, bus_b.ce_cpu, bus_b.ce_aux, bus_b.halt_ack);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus_a.sys_reset !== 1'b1 || bus_a.ce_cpu !== 1'b0 || bus_b.sys_reset !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL wait_lock cycle=%0d: got sys_reset a=%b b=%b ce_cpu_a=%b expected 1 1 0",
                         i, bus_a.sys_reset, bus_b.sys_reset, bus_a.ce_cpu);
            end
        end
    endtask

    task automatic test_lock_sequencing();
        do_lock_sequence("lock");
    endtask

    task automatic test_fractional_rate();
        int exp_first[3];
        int got;
        exp_first[0] = 4;
        exp_first[1] = 7;
        exp_first[2] = 10;
        spacing_a_on = 1'b1;
        repeat (1000) step(1'b0);
        spacing_a_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = (i < first_a.size()) ? first_a[i] : -1;
            vectors++;
            if (got !== exp_first[i]) begin
                miscompares++;
                $display("[TB] FAIL first_pulse_%0d: got RUN cycle %0d expected %0d", i, got, exp_first[i]);
            end
        end
        vectors++;
        if (cnt_a !== 300) begin
            miscompares++;
            $display("[TB] FAIL pulse_count_a: got %0d expected 300", cnt_a);
        end
    endtask

    task automatic test_halt();
        for (int ep = 0; ep < 16; ep++) begin
            repeat ($urandom_range(0, 6)) step(1'b0);
            repeat ($urandom_range(1, 14)) step(1'b1);
        end
        repeat (4) step(1'b0);
    endtask

    task automatic test_default_rate();
        while (n < 21600) step(1'b0);
        vectors++;
        if (!(cnt_b == 3579 || cnt_b == 3580)) begin
            miscompares++;
            $display("[TB] FAIL pulse_count_b: got %0d expected 3579 or 3580", cnt_b);
        end
    endtask

    task automatic test_lock_loss();
        int waited;
        waited = 0;
        while (!model_ack && waited < 20) begin
            step(1'b1);
            waited++;
        end
        vectors++;
        if (bus_a.halt_ack !== 1'b1 || waited > 5) begin
            miscompares++;
            $display("[TB] FAIL halt_ack_rise: got halt_ack=%b after %0d cycles expected 1 within 5",
                     bus_a.halt_ack, waited);
        end
        set_lock(1'b0);
        step(1'b1);
        step(1'b1);
        tick();
        vectors++;
        if ({bus_a.sys_reset, bus_a.ce_cpu, bus_a.ce_aux, bus_a.halt_ack} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL lock_loss_a: got %b%b%b%b expected 1000",
                     bus_a.sys_reset, bus_a.ce_cpu, bus_a.ce_aux, bus_a.halt_ack);
        end
        vectors++;
        if ({bus_b.sys_reset, bus_b.ce_cpu, bus_b.ce_aux} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL lock_loss_b: got %b%b%b expected 100",
                     bus_b.sys_reset, bus_b.ce_cpu, bus_b.ce_aux);
        end
        bus_a.halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus_a.sys_reset, bus_a.ce_cpu, bus_a.halt_ack, bus_b.sys_reset} !== 4'b1001) begin
                miscompares++;
                $display("[TB] FAIL unlocked cycle=%0d: got %b%b%b%b expected 1001", i,
                         bus_a.sys_reset, bus_a.ce_cpu, bus_a.halt_ack, bus_b.sys_reset);
            end
        end
        do_lock_sequence("relock");
        repeat (15) step(1'b0);
        repeat (30) step(1'($urandom_range(0, 1)));
        repeat (3) step(1'b0);
    endtask

    task automatic test_glitch();
        int   g;
        logic exp_rst;
        g = $urandom_range(3, 4);
        set_lock(1'b0);
        bus_a.halt_req = 1'b0;
        repeat (5) tick();
        set_lock(1'b1);
        for (int e = 1; e <= g + 10; e++) begin
            if (e == g + 1) set_lock(1'b0);
            if (e == g + 4) set_lock(1'b1);
            tick();
            exp_rst = (e < g + 10);
            vectors++;
            if (bus_a.sys_reset !== exp_rst || bus_b.sys_reset !== exp_rst) begin
                miscompares++;
                $display("[TB] FAIL glitch_sys_reset g=%0d edge=%0d: got a=%b b=%b expected %b",
                         g, e, bus_a.sys_reset, bus_b.sys_reset, exp_rst);
            end
            if (exp_rst) begin
                vectors++;
                if ({bus_a.ce_cpu, bus_a.ce_aux, bus_b.ce_cpu, bus_b.ce_aux} !== 4'b0) begin
                    miscompares++;
                    $display("[TB] FAIL glitch_enables edge=%0d: got %b%b%b%b expected 0000", e,
                             bus_a.ce_cpu, bus_a.ce_aux, bus_b.ce_cpu, bus_b.ce_aux);
                end
            end
        end
        start_run();
        repeat (40) step(1'($urandom_range(0, 1)));
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        spacing_a_on = 1'b0;
        start_run();
        test_reset();
        test_lock_sequencing();
        test_fractional_rate();
        test_halt();
        test_default_rate();
        test_lock_loss();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
